seg7_scan_ctrl: RTL



---
 rtl/seg7_scan_ctrl.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed hex driver for a common-select 7-segment bank with gap blanking,
// leading-zero suppression and frame-synchronous shadow latching. Optional macro: SEG7_DIM_EN.
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS = 8,
    parameter int CLK_DIV    = 125000,
    parameter int GAP_TICKS  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] data,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   blank,
    input  logic                    lz_suppress,
`ifdef SEG7_DIM_EN
    input  logic [3:0]              brightness,
`endif
    output logic [NUM_DIGITS-1:0]   num_scan_select,
    output logic [7:0]              num_seg7,
    output logic                    frame_done
);

    localparam int CW = $clog2(CLK_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int GW = $clog2(GAP_TICKS + 2);
    localparam logic [CW-1:0] CNT_MAX  = CW'(CLK_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX  = IW'(NUM_DIGITS - 1);
    localparam logic [GW-1:0] GAP_LAST = (GAP_TICKS > 0) ? GW'(GAP_TICKS - 1) : '0;

    typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q;
    logic [IW-1:0]           idx_q, idx_d;
    logic [GW-1:0]           gap_q, gap_d;
    logic [4*NUM_DIGITS-1:0] sh_data_q, sh_data_d;
    logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d;
    logic [NUM_DIGITS-1:0]   sh_blank_q, sh_blank_d;
    logic                    sh_lz_q, sh_lz_d;
    logic [NUM_DIGITS-1:0]   sel_q, sel_d;
    logic [7:0]              seg_q, seg_d;
    logic                    fd_q, fd_d;
    logic                    tick, latch, adv;
    logic [NUM_DIGITS-1:0]   supp;
`ifdef SEG7_DIM_EN
    logic [3:0]              sh_bright_q, sh_bright_d;
    logic [3:0]              pwm_q, pwm_d;
`endif

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        case (nib)
            4'h0: seg_decode = 7'h7E;
            4'h1: seg_decode = 7'h30;
            4'h2: seg_decode = 7'h6D;
            4'h3: seg_decode = 7'h79;
            4'h4: seg_decode = 7'h33;
            4'h5: seg_decode = 7'h5B;
            4'h6: seg_decode = 7'h5F;
            4'h7: seg_decode = 7'h70;
            4'h8: seg_decode = 7'h7F;
            4'h9: seg_decode = 7'h7B;
            4'hA: seg_decode = 7'h77;
            4'hB: seg_decode = 7'h1F;
            4'hC: seg_decode = 7'h4E;
            4'hD: seg_decode = 7'h3D;
            4'hE: seg_decode = 7'h4F;
            default: seg_decode = 7'h47;
        endcase
    endfunction

    assign tick = (cnt_q == CNT_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= IDX_MAX;
            gap_q      <= '0;
            sh_data_q  <= '0;
            sh_dp_q    <= '0;
            sh_blank_q <= '0;
            sh_lz_q    <= 1'b0;
            sel_q      <= '1;
            seg_q      <= '0;
            fd_q       <= 1'b0;
`ifdef SEG7_DIM_EN
            sh_bright_q <= '0;
            pwm_q       <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= tick ? '0 : cnt_q + CW'(1);
            idx_q      <= idx_d;
            gap_q      <= gap_d;
            sh_data_q  <= sh_data_d;
            sh_dp_q    <= sh_dp_d;
            sh_blank_q <= sh_blank_d;
            sh_lz_q    <= sh_lz_d;
            sel_q      <= sel_d;
            seg_q      <= seg_d;
            fd_q       <= fd_d;
`ifdef SEG7_DIM_EN
            sh_bright_q <= sh_bright_d;
            pwm_q       <= pwm_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        latch   = 1'b0;
        adv     = 1'b0;
        case (state_q)
            IDLE: begin
                if (tick) begin
                    latch   = 1'b1;
                    idx_d   = IDX_MAX;
                    state_d = SHOW;
                end
            end
            SHOW: begin
                if (tick) begin
                    if (GAP_TICKS > 0) begin
                        state_d = GAP;
                        gap_d   = '0;
                    end else begin
                        adv = 1'b1;
                    end
                end
            end
            GAP: begin
                if (tick) begin
                    if (gap_q == GAP_LAST) adv = 1'b1;
                    else                   gap_d = gap_q + GW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (adv) begin
            state_d = SHOW;
            if (idx_q != '0) begin
                idx_d = idx_q - IW'(1);
            end else begin
                latch = 1'b1;
                idx_d = IDX_MAX;
            end
        end
    end

    // Outputs are computed from next-state values so they are registered on the transition edge.
    always_comb begin
        sh_data_d  = latch ? data        : sh_data_q;
        sh_dp_d    = latch ? dp          : sh_dp_q;
        sh_blank_d = latch ? blank       : sh_blank_q;
        sh_lz_d    = latch ? lz_suppress : sh_lz_q;
`ifdef SEG7_DIM_EN
        sh_bright_d = latch ? brightness : sh_bright_q;
        pwm_d       = pwm_q + 4'd1;
`endif
    end

    always_comb begin
        logic zero_run;
        zero_run = 1'b1;
        supp     = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run & (sh_data_d[4*i +: 4] == 4'h0);
            supp[i]  = zero_run & sh_lz_d & (i != 0);
        end
    end

    always_comb begin
        logic [3:0] nib;
        logic       dp_b, blank_b, supp_b;
        nib     = 4'h0;
        dp_b    = 1'b0;
        blank_b = 1'b0;
        supp_b  = 1'b0;
        sel_d   = '1;
        seg_d   = '0;
        fd_d    = adv && (idx_q == '0);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (IW'(i) == idx_d) begin
                nib     = sh_data_d[4*i +: 4];
                dp_b    = sh_dp_d[i];
                blank_b = sh_blank_d[i];
                supp_b  = supp[i];
                sel_d[i] = (state_d != SHOW);
            end
        end
        if (state_d == SHOW && !blank_b) begin
            seg_d = {dp_b, supp_b ? 7'h00 : seg_decode(nib)};
        end
`ifdef SEG7_DIM_EN
        if (pwm_d > sh_bright_d) seg_d = '0;
`endif
    end

    assign num_scan_select = sel_q;
    assign num_seg7        = seg_q;
    assign frame_done      = fd_q;

endmodule
